// File: rtl/rgb565_gray_feed.sv
// rgb565_gray_feed: RGB565 CMOS byte stream to 10-bit luma, with frame/line tracking.
// Define GRAY_FRAME_SKIP_EN to hold off pixel output until SKIP_FRAMES VSYNC rises after reset.
module rgb565_gray_feed #(
   parameter int unsigned SKIP_FRAMES = 10
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iVSYNC,
   input  logic       iHREF,
   input  logic [7:0] iDATA,
   output logic       oDVAL,
   output logic [9:0] oDATA,
   output logic       oFRAME_START,
   output logic [8:0] oLINE_CNT
);
   logic        vs_q, vs_armed, href_q, phase, v0, v1, v2, emit;
   logic [7:0]  hi;
   logic [15:0] pix, p_r, p_g, p_b, sum;
   logic        vs_rise, take;
   logic [7:0]  r8, g8, b8;
   // vs_armed masks a VSYNC that is already high when reset releases
   assign vs_rise = vs_armed & iVSYNC & ~vs_q;
   assign take    = iHREF & ~iVSYNC;
   assign r8      = {pix[15:11], pix[15:13]};
   assign g8      = {pix[10:5], pix[10:9]};
   assign b8      = {pix[4:0], pix[4:2]};
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         vs_q         <= 1'b0;
         vs_armed     <= 1'b0;
         href_q       <= 1'b0;
         phase        <= 1'b0;
         hi           <= '0;
         pix          <= '0;
         v0           <= 1'b0;
         v1           <= 1'b0;
         v2           <= 1'b0;
         p_r          <= '0;
         p_g          <= '0;
         p_b          <= '0;
         sum          <= '0;
         oDVAL        <= 1'b0;
         oDATA        <= '0;
         oFRAME_START <= 1'b0;
         oLINE_CNT    <= '0;
      end else begin
         vs_q         <= iVSYNC;
         vs_armed     <= 1'b1;
         href_q       <= iHREF;
         phase        <= take & ~phase;
         if (take & ~phase) hi <= iDATA;
         if (take & phase) pix <= {hi, iDATA};
         v0           <= take & phase;
         v1           <= v0;
         p_r          <= 16'(r8) * 16'd77;
         p_g          <= 16'(g8) * 16'd150;
         p_b          <= 16'(b8) * 16'd29;
         v2           <= v1;
         sum          <= p_r + p_g + p_b;
         oDVAL        <= v2 & emit;
         oDATA        <= (v2 & emit) ? sum[15:6] : '0;
         oFRAME_START <= vs_rise;
         oLINE_CNT    <= vs_rise ? '0 :
                         (href_q & ~iHREF & ~&oLINE_CNT) ? oLINE_CNT + 9'd1 : oLINE_CNT;
      end
   end
`ifdef GRAY_FRAME_SKIP_EN
   logic [3:0] skip_cnt;
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) skip_cnt <= '0;
      else if (vs_rise && skip_cnt != 4'hF) skip_cnt <= skip_cnt + 4'd1;
   end
   assign emit = {28'd0, skip_cnt} >= SKIP_FRAMES;
`else
   logic unused_skip;
   assign unused_skip = ^SKIP_FRAMES;
   assign emit = 1'b1;
`endif
endmodule

// File: tb/tb_rgb565_gray_feed.sv
// tb_rgb565_gray_feed: directed checks of luma values, latency, line/frame tracking, reset and frame skip.
module tb_rgb565_gray_feed;
`ifdef GRAY_FRAME_SKIP_EN
   localparam bit SK = 1'b1;
`else
   localparam bit SK = 1'b0;
`endif
   logic       iCLK = 1'b0, iRST_N = 1'b0, iVSYNC = 1'b0, iHREF = 1'b0;
   logic [7:0] iDATA = '0;
   logic       oDVAL, oFRAME_START;
   logic [9:0] oDATA;
   logic [8:0] oLINE_CNT;
   int         tests = 0, fails = 0, cnt;
   bit         en;

   rgb565_gray_feed #(.SKIP_FRAMES(2)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iVSYNC(iVSYNC), .iHREF(iHREF), .iDATA(iDATA),
      .oDVAL(oDVAL), .oDATA(oDATA), .oFRAME_START(oFRAME_START), .oLINE_CNT(oLINE_CNT)
   );

   always #5 iCLK = ~iCLK;

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pixel(input logic [7:0] h, input logic [7:0] l, input logic [9:0] exp, input string tag);
      iHREF = 1'b1; iDATA = h; step();
      iDATA = l; step();
      iHREF = 1'b0; step();
      step();
      chk({tag, "_lat_n2"}, 16'(oDVAL), 16'd0);
      step();
      chk({tag, "_dval"}, 16'(oDVAL), 16'(en));
      chk({tag, "_data"}, 16'(oDATA), en ? 16'(exp) : 16'd0);
      step();
      chk({tag, "_dval_off"}, 16'(oDVAL), 16'd0);
      chk({tag, "_data_off"}, 16'(oDATA), 16'd0);
   endtask

   task automatic vs_pulse();
      iVSYNC = 1'b1; step();
      chk("fs_pulse", 16'(oFRAME_START), 16'd1);
      chk("fs_lc_clr", 16'(oLINE_CNT), 16'd0);
      iVSYNC = 1'b0; step();
      chk("fs_one_cycle", 16'(oFRAME_START), 16'd0);
   endtask

   initial begin
      // reset held, VSYNC already high at release
      iVSYNC = 1'b1; #1;
      chk("rst_dval", 16'(oDVAL), 16'd0);
      chk("rst_data", 16'(oDATA), 16'd0);
      chk("rst_fs", 16'(oFRAME_START), 16'd0);
      chk("rst_lc", 16'(oLINE_CNT), 16'd0);
      step(); step();
      iRST_N = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin step(); cnt += int'(oFRAME_START); end
      chk("vs_high_at_release", 16'(cnt), 16'd0);
      iVSYNC = 1'b0; step(); step();
      en = !SK;
      vs_pulse();
      pixel(8'hFF, 8'hFF, 10'd1020, "frame1_white");
      vs_pulse();
      en = 1'b1;
      pixel(8'hFF, 8'hFF, 10'd1020, "white");
      pixel(8'hF8, 8'h00, 10'd306, "red");
      pixel(8'h07, 8'hE0, 10'd597, "green");
      pixel(8'h00, 8'h1F, 10'd115, "blue");
      pixel(8'h00, 8'h00, 10'd0, "black");
      chk("lc_after_5_lines", 16'(oLINE_CNT), 16'd5);
      // back-to-back pixels, two cycles apart
      iHREF = 1'b1; iDATA = 8'hF8; step(); iDATA = 8'h00; step();
      iDATA = 8'h00; step(); iDATA = 8'h1F; step();
      iHREF = 1'b0; step();
      chk("b2b_first", 16'(oDVAL) << 10 | 16'(oDATA), 16'(1 << 10 | 306));
      step();
      chk("b2b_gap", 16'(oDVAL), 16'd0);
      step();
      chk("b2b_second", 16'(oDVAL) << 10 | 16'(oDATA), 16'(1 << 10 | 115));
      // odd trailing byte dropped
      iHREF = 1'b1; iDATA = 8'hFF; step(); step(); iDATA = 8'hAA; step();
      iHREF = 1'b0;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin step(); cnt += int'(oDVAL); end
      chk("odd_byte_one_pixel", 16'(cnt), 16'd1);
      chk("lc_after_odd_line", 16'(oLINE_CNT), 16'd7);
      vs_pulse();
      // simultaneous VSYNC rise and HREF fall
      iHREF = 1'b1; step(); iHREF = 1'b0; step();
      chk("lc_one", 16'(oLINE_CNT), 16'd1);
      iHREF = 1'b1; step();
      iHREF = 1'b0; iVSYNC = 1'b1; step();
      chk("clear_wins_lc", 16'(oLINE_CNT), 16'd0);
      chk("clear_wins_fs", 16'(oFRAME_START), 16'd1);
      // bytes during VSYNC ignored
      iHREF = 1'b1; iDATA = 8'hFF; step(); step(); step(); step();
      iHREF = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin step(); cnt += int'(oDVAL); end
      chk("vsync_href_ignored", 16'(cnt), 16'd0);
      iVSYNC = 1'b0; step();
      vs_pulse();
      for (int i = 0; i < 520; i++) begin iHREF = 1'b1; step(); iHREF = 1'b0; step(); end
      chk("lc_saturate", 16'(oLINE_CNT), 16'd511);
      // reset between phase-1 byte and output
      iHREF = 1'b1; iDATA = 8'hFF; step(); step();
      iHREF = 1'b0; step();
      iRST_N = 1'b0; #1;
      chk("midrst_dval", 16'(oDVAL), 16'd0);
      chk("midrst_data", 16'(oDATA), 16'd0);
      chk("midrst_lc", 16'(oLINE_CNT), 16'd0);
      step();
      iRST_N = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin step(); cnt += int'(oDVAL); end
      chk("midrst_no_pixel", 16'(cnt), 16'd0);
      en = !SK;
      pixel(8'hF8, 8'h00, 10'd306, "post_rst_red");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rgb565_gray_feed.md
RGB565_GRAY_FEED -- requirements
Module: rgb565_gray_feed

Interface
REQ-001 Parameter SKIP_FRAMES, default 10: number of VSYNC rising edges after reset before pixels are emitted; used only with GRAY_FRAME_SKIP_EN.
REQ-002 iCLK  input  1  CMOS pixel clock; all logic on rising edge.
REQ-003 iRST_N  input  1  reset, asynchronous, active-low.
REQ-004 iVSYNC  input  1  CMOS frame sync, active high.
REQ-005 iHREF  input  1  CMOS line valid, active high.
REQ-006 iDATA  input  8  CMOS byte; RGB565, high byte first.
REQ-007 oDVAL  output  1  luma valid, one cycle per pixel; feeds the edge-detect stage's iDVAL.
REQ-008 oDATA  output  10  luma, 0..1020; feeds the edge-detect stage's iDATA.
REQ-009 oFRAME_START  output  1  one-cycle pulse on a detected VSYNC rising edge.
REQ-010 oLINE_CNT  output  9  completed lines in the current frame, saturating.

Function
REQ-011 Byte phase flag: cleared while iHREF=0; toggles on every cycle with iHREF=1.
REQ-012 Phase 0 byte stored as high byte; phase 1 byte completes the pixel: R5=hi[7:3], G6={hi[2:0],lo[7:5]}, B5=lo[4:0].
REQ-013 Expansion to 8 bits: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-014 Sum S = 77*R8 + 150*G8 + 29*B8 (16 bits unsigned; maximum 65280, no overflow); oDATA = S[15:6] (truncate).
REQ-015 Pipeline stages: (1) three products registered; (2) sum registered; (3) output register.
REQ-016 Latency: if the phase-1 byte is sampled at edge N, oDVAL=1 with that pixel's oDATA after edge N+3.
REQ-017 Pipeline is unstalled: a new pixel can start every 2 cycles; there is no backpressure.
REQ-018 oDATA = 0 in every cycle where oDVAL = 0.
REQ-019 A trailing odd byte (iHREF falls in phase 1) is discarded and produces no pixel.
REQ-020 iVSYNC is registered once; a 0->1 transition generates:
  - one oFRAME_START pulse;
  - oLINE_CNT cleared to 0;
  - byte phase cleared.
REQ-021 oLINE_CNT increments on each iHREF 1->0 transition and saturates at 511.
REQ-022 iHREF=1 while iVSYNC=1: bytes ignored and no pixel produced.
REQ-023 Simultaneous VSYNC rise and HREF fall in the same cycle: the clear wins and oLINE_CNT = 0.
REQ-024 Pixels already in the pipeline at a VSYNC rise still complete and are emitted.

Reset
REQ-025 On iRST_N=0, all outputs are 0 immediately (asynchronous): oDVAL, oDATA, oFRAME_START, oLINE_CNT.
REQ-026 On iRST_N=0, all internal state clears: phase, pipeline valids, VSYNC history, skip counter.
REQ-027 Reset mid-line or mid-pipeline discards all in-flight pixels; the first pixel after release starts at phase 0.
REQ-028 A VSYNC already high when reset is released is not a rising edge.

Configuration
REQ-029 Macro GRAY_FRAME_SKIP_EN, when defined:
  - a 4-bit saturating counter counts VSYNC rising edges from reset;
  - oDVAL and oDATA are forced to 0 until the count reaches SKIP_FRAMES;
  - oFRAME_START and oLINE_CNT operate normally.
REQ-030 Macro GRAY_FRAME_SKIP_EN, when undefined: no counter is built and pixels are emitted from the first HREF after reset.

Verification
REQ-031 HREF=1 for 2 cycles, bytes 0xFF,0xFF -> oDVAL=1 and oDATA=1020 exactly 3 edges after the second byte.
REQ-032 Bytes 0xF8,0x00 -> 306; bytes 0x07,0xE0 -> 597; bytes 0x00,0x1F -> 115; bytes 0x00,0x00 -> 0.
REQ-033 HREF=1 for 3 cycles -> exactly one oDVAL pulse; oLINE_CNT=1 after the HREF fall.
REQ-034 VSYNC pulse after 3 lines:
  - oFRAME_START high for exactly 1 cycle;
  - oLINE_CNT=0;
  - 520 HREF pulses -> oLINE_CNT holds 511.
REQ-035 Frame skip, SKIP_FRAMES=2:
  - with GRAY_FRAME_SKIP_EN: no oDVAL after VSYNC #1, pixels emitted after VSYNC #2;
  - without GRAY_FRAME_SKIP_EN: pixels emitted in both frames.
REQ-036 iRST_N pulsed low between a pixel's phase-1 byte and its output -> no oDVAL for that pixel, all outputs 0; the next 2-byte pair is decoded correctly.
